shift_unit: RTL

//  Shift register stage of the multicycle MIPS datapath. It is driven directly by the control unit's

---
 rtl/shift_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/shift_unit.sv
// Shift/rotate stage of the multicycle MIPS datapath: latches a source word and
// amount on LOAD_SRC, then shifts or rotates the held word in place, one command per cycle.
module shift_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [4:0] CONST_AMT = 5'd16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       shift_control,
    input  logic             shift_src_control,
    input  logic [1:0]       shift_amount_control,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] shift_out,
    output logic [4:0]       shift_amt,
    output logic             shift_zero
);

    typedef enum logic [2:0] {
        CMD_NOP       = 3'b000,
        CMD_LOAD_SRC  = 3'b001,
        CMD_LEFT_ARTH = 3'b010,
        CMD_RIGHT_LOG = 3'b011,
        CMD_RIGHT_ART = 3'b100,
        CMD_ROTATE_RT = 3'b101,
        CMD_ROTATE_LT = 3'b110,
        CMD_RESERVED  = 3'b111
    } shift_cmd_e;

    shift_cmd_e       cmd;
    logic [4:0]       load_amt;
    logic [WIDTH-1:0] next_out;
    logic [4:0]       next_amt;

    assign cmd = shift_cmd_e'(shift_control);

    always_comb begin
        load_amt = 5'd0;
        case (shift_amount_control)
            2'b00:   load_amt = reg_a[4:0];
            2'b01:   load_amt = reg_b[4:0];
            2'b10:   load_amt = shamt;
            default: load_amt = CONST_AMT;
        endcase
    end

    // Ops always use the latched amount; a zero amount is an explicit pass-through
    // so the complementary half of a rotate never sees a full-width shift.
    always_comb begin
        next_out = shift_out;
        next_amt = shift_amt;
        case (cmd)
            CMD_LOAD_SRC: begin
                next_out = shift_src_control ? reg_b : reg_a;
                next_amt = load_amt;
            end
            CMD_LEFT_ARTH: next_out = shift_out << shift_amt;
            CMD_RIGHT_LOG: next_out = shift_out >> shift_amt;
            CMD_RIGHT_ART: next_out = $signed(shift_out) >>> shift_amt;
            CMD_ROTATE_RT: begin
                if (shift_amt != 5'd0)
                    next_out = (shift_out >> shift_amt) |
                               (shift_out << (6'(WIDTH) - {1'b0, shift_amt}));
            end
            CMD_ROTATE_LT: begin
                if (shift_amt != 5'd0)
                    next_out = (shift_out << shift_amt) |
                               (shift_out >> (6'(WIDTH) - {1'b0, shift_amt}));
            end
            default: begin
                next_out = shift_out;
                next_amt = shift_amt;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_out <= '0;
            shift_amt <= 5'd0;
        end else begin
            shift_out <= next_out;
            shift_amt <= next_amt;
        end
    end

    assign shift_zero = (shift_out == '0);

endmodule
